// File: rtl/vga_pkg.sv
// Shared constants for the VGA output stage: default 640x480@60 timing,
// sync polarity encodings and a small window-decode helper.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_COLOR_W    = 8;
    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_FIFO_DEPTH = 16;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Half-open window test used for the sync pulse decode.
    function automatic logic in_range(input int val, input int lo, input int hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_stream_out_pixel_fifo.sv
// Small synchronous pixel FIFO with wrap-bit pointers and a flush input.
// Reads are combinational from the array; the consumer registers the word.
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             ready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_wr;
    logic             do_rd;

    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign ready = !full;

    // Fullness is judged before any same-cycle pop, so a full FIFO never takes a word.
    assign do_wr = wr_en && !full && !flush;
    assign do_rd = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vga_stream_out.sv
// Programmable VGA timing generator that pops {sof,R,G,B} words from a pixel
// FIFO during the active region and drives registered colour and sync outputs.
module vga_stream_out
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter int   COLOR_W    = DEF_COLOR_W,
    parameter int   CLK_DIV    = DEF_CLK_DIV,
    parameter int   FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic SYNC_POL   = SYNC_ACTIVE_LOW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [3*COLOR_W-1:0] pix_data,
    input  logic                 pix_sof,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 blank_n,
    output logic                 frame_done,
    output logic                 underflow,
    output logic                 sof_err
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW      = 3 * COLOR_W;
    localparam int FW      = PW + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    logic [DW-1:0] div_cnt_reg;
    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;
    logic          enable_d_reg;
    logic          ready_en_reg;

    rgb_t          rgb_reg;
    logic          hsync_reg;
    logic          vsync_reg;
    logic          blank_n_reg;
    logic          frame_done_reg;
    logic          underflow_reg;
    logic          sof_err_reg;

    logic          tick;
    logic          h_last;
    logic          v_last;
    logic          active;
    logic          at_origin;
    logic          hsync_next;
    logic          vsync_next;
    logic          flush;
    logic          fifo_push;
    logic          fifo_pop;
    logic [FW-1:0] fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_ready;
    logic          fifo_sof;
    rgb_t          fifo_pix;

    assign tick      = enable && (div_cnt_reg == DIV_LAST);
    assign h_last    = (h_cnt_reg == H_LAST);
    assign v_last    = (v_cnt_reg == V_LAST);
    assign active    = (int'(h_cnt_reg) < H_ACTIVE) && (int'(v_cnt_reg) < V_ACTIVE);
    assign at_origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);

    assign hsync_next = in_range(int'(h_cnt_reg), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC)
                        ? SYNC_POL : !SYNC_POL;
    assign vsync_next = in_range(int'(v_cnt_reg), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC)
                        ? SYNC_POL : !SYNC_POL;

    // Only the falling edge of enable empties the FIFO; a disabled stage still buffers.
    assign flush = enable_d_reg && !enable;

    assign pix_ready = ready_en_reg && fifo_ready;
    assign fifo_push = pix_valid && ready_en_reg && !fifo_full;
    assign fifo_pop  = tick && active && !fifo_empty;
    assign fifo_sof  = fifo_rd_data[FW-1];
    assign fifo_pix  = rgb_t'(fifo_rd_data[PW-1:0]);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (fifo_push),
        .wr_data ({pix_sof, pix_data}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ready   (fifo_ready)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_reg  <= '0;
            h_cnt_reg    <= '0;
            v_cnt_reg    <= '0;
            enable_d_reg <= 1'b0;
            ready_en_reg <= 1'b0;
        end else begin
            enable_d_reg <= enable;
            ready_en_reg <= 1'b1;
            if (!enable) begin
                div_cnt_reg <= '0;
                h_cnt_reg   <= '0;
                v_cnt_reg   <= '0;
            end else begin
                div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DW'(1);
                if (tick) begin
                    if (h_last) begin
                        h_cnt_reg <= '0;
                        v_cnt_reg <= v_last ? '0 : v_cnt_reg + VW'(1);
                    end else begin
                        h_cnt_reg <= h_cnt_reg + HW'(1);
                    end
                end
            end
        end
    end

    // Outputs capture the pre-increment counter state, so they trail the tick by one clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_reg        <= '0;
            hsync_reg      <= !SYNC_POL;
            vsync_reg      <= !SYNC_POL;
            blank_n_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            underflow_reg  <= 1'b0;
            sof_err_reg    <= 1'b0;
        end else if (!enable) begin
            rgb_reg        <= '0;
            hsync_reg      <= !SYNC_POL;
            vsync_reg      <= !SYNC_POL;
            blank_n_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            underflow_reg  <= 1'b0;
            sof_err_reg    <= 1'b0;
        end else begin
            frame_done_reg <= tick && h_last && v_last;
            if (tick) begin
                hsync_reg   <= hsync_next;
                vsync_reg   <= vsync_next;
                blank_n_reg <= active;
                rgb_reg     <= (active && !fifo_empty) ? fifo_pix : '0;
                if (active && fifo_empty) begin
                    underflow_reg <= 1'b1;
                end
                if (active && !fifo_empty && (fifo_sof != at_origin)) begin
                    sof_err_reg <= 1'b1;
                end
            end
        end
    end

    assign red        = rgb_reg.r;
    assign green      = rgb_reg.g;
    assign blue       = rgb_reg.b;
    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign blank_n    = blank_n_reg;
    assign frame_done = frame_done_reg;
    assign underflow  = underflow_reg;
    assign sof_err    = sof_err_reg;

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out on a 14x7 test raster (CLK_DIV 1 and 2).
module tb_vga_stream_out;

    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          enable = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic [23:0]   pix_data = '0;
    logic          pix_ready;
    logic [CW-1:0] red, green, blue;
    logic          hsync, vsync, blank_n, frame_done, underflow, sof_err;

    logic          e2_enable = 1'b0;
    logic          e2_valid = 1'b0;
    logic          e2_sof = 1'b0;
    logic [23:0]   e2_data = '0;
    logic          e2_ready;
    logic [CW-1:0] red2, green2, blue2;
    logic          hsync2, vsync2, blank2, fdone2, uflow2, soferr2;

    int checks = 0;
    int errors = 0;

    logic [24:0] src [0:63];
    int          src_n = 0;
    int          src_idx = 0;

    vga_stream_out #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_W(CW), .CLK_DIV(1), .FIFO_DEPTH(4), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
        .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
        .blank_n(blank_n), .frame_done(frame_done), .underflow(underflow), .sof_err(sof_err)
    );

    vga_stream_out #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_W(CW), .CLK_DIV(2), .FIFO_DEPTH(4), .SYNC_POL(1'b0)
    ) dut2 (
        .clk(clk), .reset(reset), .enable(e2_enable),
        .pix_valid(e2_valid), .pix_ready(e2_ready), .pix_data(e2_data), .pix_sof(e2_sof),
        .red(red2), .green(green2), .blue(blue2), .hsync(hsync2), .vsync(vsync2),
        .blank_n(blank2), .frame_done(fdone2), .underflow(uflow2), .sof_err(soferr2)
    );

    task automatic drive_src();
        pix_valid = (src_idx < src_n);
        if (src_idx < src_n) {pix_sof, pix_data} = src[src_idx];
        else {pix_sof, pix_data} = '0;
    endtask

    // One clk of the stream source: a word advances only if it was accepted at the edge.
    task automatic step();
        logic acc;
        acc = pix_valid && pix_ready;
        @(posedge clk);
        #1;
        if (acc) src_idx++;
        drive_src();
    endtask

    task automatic load_stream(input int n, input int sof_pos, input int base);
        for (int i = 0; i < n; i++) src[i] = {(i == sof_pos), 24'(base + i)};
        src_n = n;
        src_idx = 0;
        drive_src();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        e2_enable = 1'b0;
        e2_valid = 1'b0;
        src_n = 0;
        src_idx = 0;
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({red, green, blue} !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 000000", {red, green, blue}); end
        checks++;
        if ({hsync, vsync} !== 2'b11) begin errors++; $display("FAIL reset_sync got %b want 11", {hsync, vsync}); end
        checks++;
        if ({blank_n, frame_done, underflow, sof_err, pix_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {blank_n, frame_done, underflow, sof_err, pix_ready});
        end
        checks++;
        if ({e2_ready, blank2, hsync2, vsync2} !== 4'b0011) begin
            errors++; $display("FAIL reset_dut2 got %b want 0011", {e2_ready, blank2, hsync2, vsync2});
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pix_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b want 1", pix_ready); end
        $display("test_reset done");
    endtask

    task automatic test_sync_timing();
        int h, v;
        do_reset();
        load_stream(32, 0, 24'h100);
        repeat (8) step();
        enable = 1'b1;
        for (int k = 0; k < 196; k++) begin
            step();
            h = k % 14;
            v = (k / 14) % 7;
            checks++;
            if (hsync !== !(h == 10 || h == 11)) begin errors++; $display("FAIL hsync k=%0d got %b want %b", k, hsync, !(h == 10 || h == 11)); end
            checks++;
            if (vsync !== (v != 5)) begin errors++; $display("FAIL vsync k=%0d got %b want %b", k, vsync, (v != 5)); end
            checks++;
            if (blank_n !== (h < 8 && v < 4)) begin errors++; $display("FAIL blank_n k=%0d got %b want %b", k, blank_n, (h < 8 && v < 4)); end
            checks++;
            if (frame_done !== (k % 98 == 97)) begin errors++; $display("FAIL frame_done k=%0d got %b want %b", k, frame_done, (k % 98 == 97)); end
        end
        $display("test_sync_timing done");
    endtask

    task automatic test_pixel_order();
        int h, v;
        do_reset();
        load_stream(32, 0, 1);
        repeat (8) step();
        enable = 1'b1;
        for (int k = 0; k < 98; k++) begin
            step();
            h = k % 14;
            v = k / 14;
            if (h < 8 && v < 4) begin
                checks++;
                if ({red, green, blue} !== 24'(v * 8 + h + 1)) begin
                    errors++; $display("FAIL pixel_order k=%0d got %h want %h", k, {red, green, blue}, 24'(v * 8 + h + 1));
                end
            end
        end
        checks++;
        if ({underflow, sof_err} !== 2'b00) begin errors++; $display("FAIL order_flags got %b want 00", {underflow, sof_err}); end
        $display("test_pixel_order done");
    endtask

    task automatic test_underflow();
        do_reset();
        load_stream(5, 0, 24'h10);
        repeat (8) step();
        enable = 1'b1;
        for (int k = 0; k < 98; k++) begin
            step();
            if (k < 5) begin
                checks++;
                if ({red, green, blue} !== 24'(16 + k) || underflow !== 1'b0) begin
                    errors++; $display("FAIL uf_pixels k=%0d got %h/%b want %h/0", k, {red, green, blue}, underflow, 24'(16 + k));
                end
            end else if (k == 5) begin
                checks++;
                if ({red, green, blue} !== 24'h0 || underflow !== 1'b1) begin
                    errors++; $display("FAIL uf_pixel6 got %h/%b want 000000/1", {red, green, blue}, underflow);
                end
            end else begin
                checks++;
                if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky k=%0d got %b want 1", k, underflow); end
            end
        end
        enable = 1'b0;
        step();
        checks++;
        if ({underflow, blank_n} !== 2'b00) begin errors++; $display("FAIL uf_clear got %b want 00", {underflow, blank_n}); end
        $display("test_underflow done");
    endtask

    task automatic test_full_fifo();
        do_reset();
        load_stream(5, 0, 24'hA0);
        step();
        repeat (4) step();
        checks++;
        if (pix_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", pix_ready); end
        repeat (3) step();
        checks++;
        if (pix_ready !== 1'b0) begin errors++; $display("FAIL full_hold got %b want 0", pix_ready); end
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) begin
                checks++;
                if (pix_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got %b want 1", pix_ready); end
            end
            checks++;
            if ({red, green, blue} !== 24'(160 + k)) begin
                errors++; $display("FAIL full_order k=%0d got %h want %h", k, {red, green, blue}, 24'(160 + k));
            end
        end
        $display("test_full_fifo done");
    endtask

    task automatic test_sof_misalign();
        do_reset();
        load_stream(8, 1, 24'h40);
        repeat (8) step();
        checks++;
        if (sof_err !== 1'b0) begin errors++; $display("FAIL sof_pre got %b want 0", sof_err); end
        enable = 1'b1;
        step();
        checks++;
        if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_first got %b want 1", sof_err); end
        repeat (5) step();
        checks++;
        if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_sticky got %b want 1", sof_err); end
        $display("test_sof_misalign done");
    endtask

    task automatic test_clk_div2();
        logic [23:0] exp_rgb;
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            e2_valid = 1'b1;
            e2_sof = (i == 0);
            e2_data = 24'(24'h200 + i);
            @(posedge clk);
            #1;
        end
        e2_valid = 1'b0;
        e2_enable = 1'b1;
        for (int e = 0; e < 9; e++) begin
            @(posedge clk);
            #1;
            exp_rgb = (e == 0) ? 24'h0 : 24'(24'h200 + (e - 1) / 2);
            checks++;
            if ({red2, green2, blue2} !== exp_rgb || blank2 !== (e != 0)) begin
                errors++; $display("FAIL div2_hold e=%0d got %h/%b want %h/%b", e, {red2, green2, blue2}, blank2, exp_rgb, (e != 0));
            end
        end
        e2_enable = 1'b0;
        $display("test_clk_div2 done");
    endtask

    task automatic test_reset_midframe();
        do_reset();
        load_stream(32, 0, 24'h300);
        repeat (8) step();
        enable = 1'b1;
        for (int k = 0; k <= 32; k++) step();
        checks++;
        if ({red, green, blue} !== 24'h314 || blank_n !== 1'b1) begin
            errors++; $display("FAIL pre_reset got %h/%b want 000314/1", {red, green, blue}, blank_n);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({red, green, blue} !== 24'h0 || {hsync, vsync} !== 2'b11) begin
            errors++; $display("FAIL async_reset_out got %h/%b want 000000/11", {red, green, blue}, {hsync, vsync});
        end
        checks++;
        if ({blank_n, frame_done, underflow, sof_err, pix_ready} !== 5'b0) begin
            errors++; $display("FAIL async_reset_flags got %b want 00000", {blank_n, frame_done, underflow, sof_err, pix_ready});
        end
        src_n = 0;
        drive_src();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (blank_n !== (k < 8) || hsync !== !(k == 10 || k == 11) || vsync !== 1'b1) begin
                errors++; $display("FAIL restart k=%0d got %b%b%b want %b%b1", k, blank_n, hsync, vsync, (k < 8), !(k == 10 || k == 11));
            end
        end
        $display("test_reset_midframe done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sync_timing();
        test_pixel_order();
        test_underflow();
        test_full_fifo();
        test_sof_misalign();
        test_clk_div2();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
